// File: rtl/freqmeter.sv
// Edge-counting frequency (edges per gate window) and period (clk cycles between rising edges) meter.
// Latency: sig_in rise to edge 2-3 cycles; freq/period register one cycle after window close / edge.
// No backpressure: freq_valid and per_valid are single-cycle strobes and are not held for a consumer.
module freqmeter #(
  parameter int F0     = 50_000_000,
  parameter int F_GATE = 1_000,
  parameter int FREQ_W = 16,
  parameter int PER_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sig_in,
  output logic [FREQ_W-1:0] freq,
  output logic              freq_valid,
  output logic              freq_ovf,
  output logic [PER_W-1:0]  period,
  output logic              per_valid,
  output logic              per_ovf
);

  localparam int GATE = F0 / F_GATE;
  localparam int G_W  = (GATE > 1) ? $clog2(GATE) : 1;
  localparam logic [G_W-1:0]    G_LAST = G_W'(GATE - 1);
  localparam logic [FREQ_W-1:0] F_MAX  = '1;
  localparam logic [PER_W-1:0]  P_MAX  = '1;

  // input conditioning
  logic s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic sig_edge;

  // gate window
  logic [G_W-1:0] g_q, g_d;
  logic           win_close;

  // edge counting
  logic [FREQ_W-1:0] ecnt_q, ecnt_d, ecnt_next;
  logic              sat_q, sat_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              freq_ovf_q, freq_ovf_d;
  logic              freq_valid_q, freq_valid_d;

  // period counting
  logic [PER_W-1:0] pcnt_q, pcnt_d;
  logic             pcnt_full;
  logic             armed_q, armed_d;
  logic [PER_W-1:0] period_q, period_d;
  logic             per_ovf_q, per_ovf_d;
  logic             per_valid_q, per_valid_d;

  // Next-state logic: synchronizer, gate counter, saturating edge and period counters.
  always_comb begin
    // Synchronize sig_in and detect its rising edge one flop later.
    s1_d     = sig_in;
    s2_d     = s1_q;
    s3_d     = s2_q;
    sig_edge = s2_q & ~s3_q;

    win_close = (g_q == G_LAST);
    g_d       = win_close ? '0 : g_q + 1'b1;

    // An edge landing on the closing cycle belongs to the closing window.
    ecnt_next = (sig_edge && (ecnt_q != F_MAX)) ? ecnt_q + 1'b1 : ecnt_q;

    ecnt_d       = ecnt_next;
    sat_d        = sat_q | (ecnt_next == F_MAX);
    freq_d       = freq_q;
    freq_ovf_d   = freq_ovf_q;
    freq_valid_d = win_close;
    if (win_close) begin
      freq_d     = ecnt_next;
      freq_ovf_d = sat_q | (ecnt_next == F_MAX);
      ecnt_d     = '0;
      sat_d      = 1'b0;
    end

    // pcnt holds the number of cycles elapsed since the previous edge.
    pcnt_full   = (pcnt_q == P_MAX);
    pcnt_d      = sig_edge ? PER_W'(1) : (pcnt_full ? pcnt_q : pcnt_q + 1'b1);
    armed_d     = armed_q | sig_edge;
    per_valid_d = sig_edge & armed_q;
    period_d    = per_valid_d ? pcnt_q : period_q;
    per_ovf_d   = per_valid_d ? pcnt_full : per_ovf_q;
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      g_q          <= '0;
      ecnt_q       <= '0;
      sat_q        <= 1'b0;
      freq_q       <= '0;
      freq_ovf_q   <= 1'b0;
      freq_valid_q <= 1'b0;
      pcnt_q       <= '0;
      armed_q      <= 1'b0;
      period_q     <= '0;
      per_ovf_q    <= 1'b0;
      per_valid_q  <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      g_q          <= g_d;
      ecnt_q       <= ecnt_d;
      sat_q        <= sat_d;
      freq_q       <= freq_d;
      freq_ovf_q   <= freq_ovf_d;
      freq_valid_q <= freq_valid_d;
      pcnt_q       <= pcnt_d;
      armed_q      <= armed_d;
      period_q     <= period_d;
      per_ovf_q    <= per_ovf_d;
      per_valid_q  <= per_valid_d;
    end
  end

  assign freq       = freq_q;
  assign freq_ovf   = freq_ovf_q;
  assign freq_valid = freq_valid_q;
  assign period     = period_q;
  assign per_ovf    = per_ovf_q;
  assign per_valid  = per_valid_q;

endmodule

// File: tb/tb_freqmeter.sv
// Bench for freqmeter: two instances (wide and narrow counters) share one stimulus.
// Reference model tracks edge cycles, window contents and edge spacing with plain arithmetic.
// Outputs are sampled 1 time unit after each rising clk edge.
module tb_freqmeter;

  localparam int F0     = 1000;
  localparam int F_GATE = 10;
  localparam int GATE   = F0 / F_GATE;
  localparam int FW_A = 16, PW_A = 24;
  localparam int FW_B = 3,  PW_B = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sig_in = 1'b0;

  logic [FW_A-1:0] freq_a;
  logic            fv_a, fovf_a, pv_a, povf_a;
  logic [PW_A-1:0] per_a;
  logic [FW_B-1:0] freq_b;
  logic            fv_b, fovf_b, pv_b, povf_b;
  logic [PW_B-1:0] per_b;

  freqmeter #(.F0(F0), .F_GATE(F_GATE), .FREQ_W(FW_A), .PER_W(PW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
    .freq(freq_a), .freq_valid(fv_a), .freq_ovf(fovf_a),
    .period(per_a), .per_valid(pv_a), .per_ovf(povf_a)
  );

  freqmeter #(.F0(F0), .F_GATE(F_GATE), .FREQ_W(FW_B), .PER_W(PW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
    .freq(freq_b), .freq_valid(fv_b), .freq_ovf(fovf_b),
    .period(per_b), .per_valid(pv_b), .per_ovf(povf_b)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  int cyc      = 0;   // clk edges since reset release
  int wincnt   = 0;   // true edges seen in the open window
  int freq_raw = 0;   // true edge count of the last closed window
  int per_raw  = 0;   // true spacing of the last two edges
  int last_e   = 0;
  bit armed    = 0;
  bit prev_sig = 0;
  bit exp_fv   = 0;
  bit exp_pv   = 0;
  int edge_q[$];      // cycles in which the conditioned edge is expected

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
  endtask

  function automatic int sat_val(input int v, input int w);
    int m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic bit ovf_val(input int v, input int w);
    return v >= ((1 << w) - 1);
  endfunction

  task automatic check_outputs();
    check("a_freq_valid", 32'(fv_a),   32'(exp_fv));
    check("a_freq",       32'(freq_a), 32'(sat_val(freq_raw, FW_A)));
    check("a_freq_ovf",   32'(fovf_a), 32'(ovf_val(freq_raw, FW_A)));
    check("a_per_valid",  32'(pv_a),   32'(exp_pv));
    check("a_period",     32'(per_a),  32'(sat_val(per_raw, PW_A)));
    check("a_per_ovf",    32'(povf_a), 32'(ovf_val(per_raw, PW_A)));
    check("b_freq_valid", 32'(fv_b),   32'(exp_fv));
    check("b_freq",       32'(freq_b), 32'(sat_val(freq_raw, FW_B)));
    check("b_freq_ovf",   32'(fovf_b), 32'(ovf_val(freq_raw, FW_B)));
    check("b_per_valid",  32'(pv_b),   32'(exp_pv));
    check("b_period",     32'(per_b),  32'(sat_val(per_raw, PW_B)));
    check("b_per_ovf",    32'(povf_b), 32'(ovf_val(per_raw, PW_B)));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_out"}, {7'd0, fv_a, fovf_a, pv_a, povf_a, 21'(freq_a | 16'(per_a))}, 32'd0);
    check({tag, "_a_per"}, 32'(per_a), 32'd0);
    check({tag, "_b_out"}, {20'd0, fv_b, fovf_b, pv_b, povf_b, 5'(freq_b), per_b}, 32'd0);
  endtask

  // One clk cycle: advance the model, compare, then drive sig_in for this cycle.
  task automatic tick(input bit v);
    @(posedge clk);
    cyc++;
    #1;
    exp_fv = 0;
    exp_pv = 0;
    while (edge_q.size() > 0 && edge_q[0] == cyc - 1) begin
      void'(edge_q.pop_front());
      wincnt++;
      if (armed) begin
        per_raw = (cyc - 1) - last_e;
        exp_pv  = 1;
      end
      armed  = 1;
      last_e = cyc - 1;
    end
    if (cyc % GATE == 0) begin
      freq_raw = wincnt;
      wincnt   = 0;
      exp_fv   = 1;
    end
    check_outputs();
    // a rise driven during cycle c becomes the edge pulse in cycle c+2
    if (v && !prev_sig) edge_q.push_back(cyc + 2);
    prev_sig = v;
    sig_in   = v;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < hi; j++) tick(1'b1);
      for (int j = 0; j < lo; j++) tick(1'b0);
    end
  endtask

  // Assert reset right after a clk edge, hold n cycles with sig_in wiggling, release low.
  task automatic reset_for(input int n);
    rst_n = 1'b0;
    #1;
    check_zero("rst_now");
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
      sig_in = 1'($urandom);
    end
    sig_in   = 1'b0;
    rst_n    = 1'b1;
    cyc      = 0;
    wincnt   = 0;
    freq_raw = 0;
    per_raw  = 0;
    last_e   = 0;
    armed    = 0;
    prev_sig = 0;
    edge_q.delete();
  endtask

  initial begin
    @(posedge clk);
    #1;
    reset_for(6);

    // steady 10-cycle square wave
    wave(5, 5, 35);

    // single edge landing on the last cycle of a window, then silence
    for (int i = 0; i < 3; i++) tick(1'b0);
    while ((cyc + 1) % GATE != GATE - 3) tick(1'b0);
    tick(1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1);
    for (int i = 0; i < 2 * GATE + 20; i++) tick(1'b0);

    // 25 edges per window saturate the narrow edge counter, then stop
    wave(2, 2, 60);
    for (int i = 0; i < 2 * GATE + 10; i++) tick(1'b0);

    // 40-cycle spacing saturates the narrow period counter, then 6-cycle spacing
    wave(20, 20, 3);
    wave(3, 3, 5);

    // randomized high/low times
    for (int i = 0; i < 120; i++) wave($urandom_range(2, 9), $urandom_range(2, 30), 1);

    // reset in the middle of a window while a square wave runs
    for (int i = 0; cyc % GATE != 50 && i < 2 * GATE; i++) tick((i % 10) < 5);
    reset_for(3);
    wave(5, 5, 25);
    for (int i = 0; i < 60; i++) wave($urandom_range(2, 6), $urandom_range(2, 6), 1);
    for (int i = 0; i < GATE + 5; i++) tick(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
